// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signals of the shared transmitter arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus UART.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 3
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_two;
  logic [N_REQ-1:0]    ack;
  logic [2:0]          grant_id;
  logic                busy;
  logic                tx_busy;
  logic                tx_start;
  logic [7:0]          tx_data;

  modport master (
    output req, req_data, req_two, tx_busy,
    input  ack, grant_id, busy, tx_start, tx_data
  );

  modport slave (
    input  req, req_data, req_two, tx_busy,
    output ack, grant_id, busy, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ word producers.
// Sends the granted word's low byte (and optionally high byte) and pulses ack on completion.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned BUSY_TO = 15
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(BUSY_TO + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state, state_d;
  logic [15:0]      word, word_d;
  logic             two, two_d;
  logic             byte_idx, byte_idx_d;
  logic [2:0]       grant_id, grant_id_d;
  logic [2:0]       last_grant, last_grant_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             tx_start, tx_start_d;
  logic [7:0]       tx_data, tx_data_d;
  logic [N_REQ-1:0] ack, ack_d;
  logic             busy, busy_d;

  logic [15:0]      words [N_REQ];
  logic             found_c;
  logic [2:0]       sel_c;
  int unsigned      cand_c;

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = bus.req_data[16*g +: 16];
  end

  // Round-robin pick: first pending request after the last one served.
  always_comb begin
    found_c = 1'b0;
    sel_c   = '0;
    cand_c  = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_c = (32'(last_grant) + k) % N_REQ;
      if (!found_c && bus.req[IW'(cand_c)]) begin
        found_c = 1'b1;
        sel_c   = 3'(cand_c);
      end
    end
  end

  always_comb begin
    state_d      = state;
    word_d       = word;
    two_d        = two;
    byte_idx_d   = byte_idx;
    grant_id_d   = grant_id;
    last_grant_d = last_grant;
    cnt_d        = cnt;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data;
    ack_d        = '0;
    unique case (state)
      IDLE: begin
        if (found_c) begin
          word_d     = words[IW'(sel_c)];
          two_d      = bus.req_two[IW'(sel_c)];
          byte_idx_d = 1'b0;
          grant_id_d = sel_c;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = byte_idx ? word[15:8] : word[7:0];
          cnt_d      = '0;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt + CW'(1);
          // UART never acknowledged the start: re-issue the same byte
          if (cnt == CW'(BUSY_TO - 1)) state_d = SEND;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (two && !byte_idx) begin
            byte_idx_d = 1'b1;
            state_d    = SEND;
          end else begin
            ack_d        = N_REQ'(1) << grant_id;
            last_grant_d = grant_id;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      word       <= '0;
      two        <= 1'b0;
      byte_idx   <= 1'b0;
      grant_id   <= '0;
      last_grant <= 3'(N_REQ - 1);
      cnt        <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      ack        <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      word       <= word_d;
      two        <= two_d;
      byte_idx   <= byte_idx_d;
      grant_id   <= grant_id_d;
      last_grant <= last_grant_d;
      cnt        <= cnt_d;
      tx_start   <= tx_start_d;
      tx_data    <= tx_data_d;
      ack        <= ack_d;
      busy       <= busy_d;
    end
  end

  assign bus.ack      = ack;
  assign bus.grant_id = grant_id;
  assign bus.busy     = busy;
  assign bus.tx_start = tx_start;
  assign bus.tx_data  = tx_data;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: UART model plus transaction-level round-robin reference model.
// Directed reset/byte/latency/timeout/abort cases followed by randomized request batches.
module tb_uart_tx_arbiter;
  localparam int unsigned N_REQ   = 3;
  localparam int unsigned BUSY_TO = 15;

  typedef struct packed {
    logic [2:0]  gid;
    logic [15:0] word;
    logic        two;
  } item_t;

  logic clk = 1'b0;
  logic reset;

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_arbiter #(.N_REQ(N_REQ), .BUSY_TO(BUSY_TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  item_t src_q[$];
  item_t exp_q[$];
  int    bidx = 0;
  int    model_last = int'(N_REQ) - 1;
  int    busy_left = 0;
  int    busy_len = 0;
  bit    rand_ignore = 1'b0;
  bit    force_ignore = 1'b0;
  bit    retry_pending = 1'b0;
  bit    scramble = 1'b0;
  int    ign_cyc = 0;
  logic [7:0] ign_byte = '0;
  int    starts = 0;
  int    first_start_cyc = 0;
  int    req_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Present each requester's oldest outstanding word; requesters with nothing left drop req.
  task automatic update_reqs();
    logic [N_REQ-1:0]    r;
    logic [N_REQ-1:0]    t;
    logic [16*N_REQ-1:0] d;
    r = '0; t = '0; d = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      bit    have;
      item_t head;
      have = 1'b0;
      head = '0;
      for (int j = 0; j < src_q.size(); j++)
        if (!have && src_q[j].gid == 3'(i)) begin
          have = 1'b1;
          head = src_q[j];
        end
      r = (r << 1) | N_REQ'(have);
      t = (t << 1) | N_REQ'(have & head.two);
      d = (d << 16) | (16*N_REQ)'(have ? head.word : 16'($urandom));
    end
    bus.req      = r;
    bus.req_two  = t;
    bus.req_data = d;
  endtask

  // Reference order: repeatedly serve the next requester after the last one that has work.
  task automatic plan();
    item_t pool[$];
    pool = src_q;
    while (pool.size() > 0) begin
      for (int k = 1; k <= int'(N_REQ); k++) begin
        int g;
        int idx;
        g   = (model_last + k) % int'(N_REQ);
        idx = -1;
        for (int j = 0; j < pool.size(); j++)
          if (idx < 0 && pool[j].gid == 3'(g)) idx = j;
        if (idx >= 0) begin
          exp_q.push_back(pool[idx]);
          pool.delete(idx);
          model_last = g;
          break;
        end
      end
    end
  endtask

  task automatic add_item(input int g, input logic [15:0] w, input logic two);
    item_t it;
    it.gid  = 3'(g);
    it.word = w;
    it.two  = two;
    src_q.push_back(it);
  endtask

  task automatic pop_src(input logic [2:0] g);
    int idx;
    idx = -1;
    for (int j = 0; j < src_q.size(); j++)
      if (idx < 0 && src_q[j].gid == g) idx = j;
    if (idx >= 0) src_q.delete(idx);
  endtask

  // One clock: sample after the falling edge, check, then update UART model and requesters.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (bus.tx_start) begin
      starts++;
      if (starts == 1) first_start_cyc = cyc;
      check_eq("start_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        logic [7:0] eb;
        eb = (bidx != 0) ? exp_q[0].word[15:8] : exp_q[0].word[7:0];
        check_eq("tx_data", 32'(bus.tx_data), 32'(eb));
        check_eq("grant_id", 32'(bus.grant_id), 32'(exp_q[0].gid));
        check_eq("busy_on_start", 32'(bus.busy), 32'(1));
      end
      if (retry_pending) begin
        check_eq("retry_gap", 32'(cyc - ign_cyc), 32'(BUSY_TO + 1));
        check_eq("retry_byte", 32'(bus.tx_data), 32'(ign_byte));
        retry_pending = 1'b0;
      end
      if (force_ignore || (rand_ignore && $urandom_range(0, 7) == 0)) begin
        force_ignore  = 1'b0;
        retry_pending = 1'b1;
        ign_cyc       = cyc;
        ign_byte      = bus.tx_data;
      end else begin
        bus.tx_busy = 1'b1;
        busy_left   = (busy_len == 0) ? int'($urandom_range(3, 10)) : busy_len;
        bidx++;
      end
      if (scramble) begin
        scramble     = 1'b0;
        bus.req      = '0;
        bus.req_data = (16*N_REQ)'({$urandom, $urandom});
        bus.req_two  = '0;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) bus.tx_busy = 1'b0;
    end
    if (bus.ack != '0) begin
      check_eq("ack_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        check_eq("ack", 32'(bus.ack), 32'(1) << exp_q[0].gid);
        check_eq("bytes_sent", 32'(bidx), exp_q[0].two ? 32'(2) : 32'(1));
        check_eq("busy_on_ack", 32'(bus.busy), 32'(0));
        pop_src(exp_q[0].gid);
        void'(exp_q.pop_front());
        bidx = 0;
        update_reqs();
      end
    end
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check_eq("drain_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic start_batch();
    plan();
    update_reqs();
    starts  = 0;
    req_cyc = cyc;
  endtask

  initial begin
    reset        = 1'b0;
    bus.req      = '1;
    bus.req_two  = '1;
    bus.req_data = (16*N_REQ)'({$urandom, $urandom});
    bus.tx_busy  = 1'b0;

    // Reset held with all requests pending
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rst_tx_start", 32'(bus.tx_start), 32'(0));
      check_eq("rst_busy", 32'(bus.busy), 32'(0));
      check_eq("rst_ack", 32'(bus.ack), 32'(0));
    end
    check_eq("rst_grant_id", 32'(bus.grant_id), 32'(0));
    check_eq("rst_tx_data", 32'(bus.tx_data), 32'(0));
    bus.req = '0;
    @(negedge clk);
    reset = 1'b1;

    // Two-byte word; request and data withdrawn after the first byte starts
    add_item(0, 16'hA55A, 1'b1);
    busy_len = 10;
    scramble = 1'b1;
    start_batch();
    run_idle(300);
    check_eq("t2_starts", 32'(starts), 32'(2));

    // Single byte plus request-to-start latency
    add_item(1, 16'h1234, 1'b0);
    start_batch();
    run_idle(300);
    check_eq("t3_starts", 32'(starts), 32'(1));
    check_eq("t3_latency", 32'(first_start_cyc - req_cyc), 32'(2));

    // All requesters pending, two words each
    busy_len = 4;
    for (int r = 0; r < 2; r++)
      for (int g = 0; g < int'(N_REQ); g++) add_item(g, 16'($urandom), 1'b1);
    start_batch();
    run_idle(1000);
    check_eq("t4_starts", 32'(starts), 32'(4 * N_REQ));

    // First start ignored by the UART
    force_ignore = 1'b1;
    add_item(2, 16'($urandom), 1'b1);
    start_batch();
    run_idle(300);
    check_eq("t5_starts", 32'(starts), 32'(3));
    check_eq("t5_retry_seen", 32'(retry_pending), 32'(0));

    // Abort during the first byte's transmission
    busy_len = 8;
    add_item(0, 16'($urandom), 1'b1);
    start_batch();
    for (int n = 0; n < 100 && bidx == 0; n++) step();
    step();
    step();
    check_eq("t6_busy_before", 32'(bus.busy), 32'(1));
    reset = 1'b0;
    #1;
    check_eq("t6_busy_abort", 32'(bus.busy), 32'(0));
    check_eq("t6_ack_abort", 32'(bus.ack), 32'(0));
    check_eq("t6_start_abort", 32'(bus.tx_start), 32'(0));
    src_q.delete();
    exp_q.delete();
    bidx       = 0;
    model_last = int'(N_REQ) - 1;
    bus.req    = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("t6_ack_in_reset", 32'(bus.ack), 32'(0));
    end
    reset = 1'b1;
    add_item(2, 16'($urandom), 1'b0);
    start_batch();
    run_idle(300);
    check_eq("t6_starts", 32'(starts), 32'(1));

    // Fresh reset, then all three at once: requester 0 must lead
    reset = 1'b0;
    model_last = int'(N_REQ) - 1;
    @(negedge clk);
    reset = 1'b1;
    add_item(1, 16'($urandom), 1'b0);
    add_item(2, 16'($urandom), 1'b0);
    add_item(0, 16'($urandom), 1'b0);
    start_batch();
    run_idle(500);

    // Randomized batches with occasional ignored starts
    busy_len    = 0;
    rand_ignore = 1'b1;
    for (int p = 0; p < 10; p++) begin
      int n;
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++)
        add_item(int'($urandom_range(0, N_REQ - 1)), 16'($urandom), 1'($urandom));
      start_batch();
      run_idle(4000);
    end
    rand_ignore = 1'b0;
    run_idle(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
